// File: rtl/seq_array_multiplier.sv
// rtl/seq_array_multiplier.sv - sequential shift-and-add signed/unsigned multiplier
//
// One adder row is reused over B_WIDTH cycles. Operands are reduced to
// magnitudes on capture, multiplied unsigned, and the sign is applied once
// at the end. This keeps the most-negative inputs exact.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        operation request, sampled only in IDLE
//   signed_mode  1 = a/b are two's complement, sampled with start
//   a            multiplicand [A_WIDTH]
//   b            multiplier [B_WIDTH]
//   busy         high in RUN and FINISH
//   done         one-cycle completion pulse, high while back in IDLE
//   product      registered result [A_WIDTH+B_WIDTH], held until next completion
module seq_array_multiplier #(
    parameter int A_WIDTH = 7,
    parameter int B_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       signed_mode,
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic                       busy,
    output logic                       done,
    output logic [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int CNT_W   = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [A_WIDTH-1:0]   ma;
    logic [B_WIDTH-1:0]   mb;
    logic                 neg;
    logic [P_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    // Magnitudes held unsigned at full operand width: -2^(N-1) maps to 2^(N-1).
    logic [A_WIDTH-1:0]   mag_a;
    logic [B_WIDTH-1:0]   mag_b;
    logic [P_WIDTH-1:0]   addend;

    assign mag_a  = (signed_mode && a[A_WIDTH-1]) ? -a : a;
    assign mag_b  = (signed_mode && b[B_WIDTH-1]) ? -b : b;
    // Zero-extend before shifting so no partial-product bits are lost.
    assign addend = {{B_WIDTH{1'b0}}, ma} << cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_CNT) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN) || (state == FINISH);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma      <= '0;
            mb      <= '0;
            neg     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            // done lands in the cycle after FINISH, when the FSM is already IDLE.
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        ma  <= mag_a;
                        mb  <= mag_b;
                        neg <= signed_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    if (mb[cnt]) begin
                        acc <= acc + addend;
                    end
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    product <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// tb/tb_seq_array_multiplier.sv - self-checking bench for seq_array_multiplier
module tb_seq_array_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [6:0]  a;
    logic [4:0]  b;
    logic        busy;
    logic        done;
    logic [11:0] product;

    int errors = 0;
    int checks = 0;

    seq_array_multiplier #(.A_WIDTH(7), .B_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sm;
        logic [6:0]  a;
        logic [4:0]  b;
        logic [11:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one operation from a point #1 after a rising edge and watch 10 edges.
    // poke=1 re-asserts start with other operands at edges 2 and 4.
    task automatic do_op(input string nm, input logic sm, input logic [6:0] av,
                         input logic [4:0] bv, input logic [11:0] exp, input bit poke);
        int busy_cnt;
        int pulses;
        int done_edge;
        logic [11:0] got;
        start = 1'b1; signed_mode = sm; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
        a = 7'($urandom); b = 5'($urandom); signed_mode = 1'($urandom);
        busy_cnt  = busy ? 1 : 0;
        pulses    = done ? 1 : 0;
        done_edge = -1;
        got       = 12'h000;
        for (int k = 1; k <= 10; k++) begin
            if (poke && (k == 2 || k == 4)) begin
                start = 1'b1; a = 7'd100; b = 5'd7; signed_mode = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (done_edge < 0) begin
                    done_edge = k;
                    got = product;
                end
            end
        end
        chk({nm, " product"}, 32'(got), 32'(exp));
        chk({nm, " latency"}, 32'(done_edge), 32'd6);
        chk({nm, " pulses"}, 32'(pulses), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd6);
        chk({nm, " held"}, 32'(product), 32'(exp));
    endtask

    vec_t vecs[8];
    vec_t bb[3];

    initial begin
        int idx;
        int last_edge;
        int seen;

        vecs[0] = '{1'b0, 7'd35,  5'd11,  12'h181};
        vecs[1] = '{1'b0, 7'd127, 5'd31,  12'hF61};
        vecs[2] = '{1'b0, 7'd0,   5'd31,  12'h000};
        vecs[3] = '{1'b1, 7'h7B,  5'd3,   12'hFF1};
        vecs[4] = '{1'b1, 7'h40,  5'h10,  12'h400};
        vecs[5] = '{1'b1, 7'd5,   5'h1F,  12'hFFB};
        vecs[6] = '{1'b1, 7'h40,  5'd15,  12'hC40};
        vecs[7] = '{1'b1, 7'h7F,  5'h1F,  12'h001};

        bb[0] = '{1'b0, 7'd12,  5'd10,  12'h078};
        bb[1] = '{1'b1, 7'h7E,  5'd9,   12'hFEE};
        bb[2] = '{1'b0, 7'd100, 5'd20,  12'h7D0};

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("reset_idle product", 32'(product), 32'd0);
            chk("reset_idle done", 32'(done), 32'd0);
            chk("reset_idle busy", 32'(busy), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
        end

        do_op("ignored_start", 1'b0, 7'd35, 5'd11, 12'h181, 1'b1);

        // Back-to-back with start held high.
        idx = 0; last_edge = 0; seen = 0;
        start = 1'b1; signed_mode = bb[0].sm; a = bb[0].a; b = bb[0].b;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (done && idx < 3) begin
                chk($sformatf("b2b%0d product", idx), 32'(product), 32'(bb[idx].exp));
                chk($sformatf("b2b%0d spacing", idx), 32'(k - last_edge), (idx == 0) ? 32'd6 : 32'd7);
                last_edge = k;
                seen++;
                idx++;
                if (idx < 3) begin
                    signed_mode = bb[idx].sm; a = bb[idx].a; b = bb[idx].b;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b count", 32'(seen), 32'd3);
        repeat (8) @(posedge clk);
        #1;

        // Reset mid-operation.
        start = 1'b1; signed_mode = 1'b0; a = 7'd35; b = 5'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort product", 32'(product), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort no_done", 32'(seen), 32'd0);
        do_op("after_abort", 1'b1, 7'h7B, 5'd3, 12'hFF1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
